// File: rtl/spi_controller_pkg.sv
// Shared types and constants for the SPI byte controller and its clock generator.
package spi_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        TEARDOWN
    } state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int unsigned        EDGE_W         = 5;
    localparam logic [EDGE_W-1:0]  EDGES_PER_BYTE = 5'd16;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI clock: raises tick_o in the cycle before an spi_clk
// edge is registered and reports which edge (1..16) of the byte that will be.
module spi_clk_gen
    import spi_controller_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena_i,
    input  logic              run_i,
    output logic              tick_o,
    output logic [EDGE_W-1:0] edge_idx_o
);

    localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

    logic [7:0] hp_cnt_q, hp_cnt_d;
    logic [3:0] edge_cnt_q, edge_cnt_d;

    assign tick_o     = run_i && (hp_cnt_q == HP_LAST);
    assign edge_idx_o = {1'b0, edge_cnt_q} + 5'd1;

    // NOTE: every _d gets its hold value first, so no path through the block can infer a latch.
    always_comb begin
        hp_cnt_d   = hp_cnt_q;
        edge_cnt_d = edge_cnt_q;
        if (!run_i) begin
            hp_cnt_d   = '0;
            edge_cnt_d = '0;
        end else if (tick_o) begin
            hp_cnt_d   = '0;
            edge_cnt_d = edge_cnt_q + 4'd1;
        end else begin
            hp_cnt_d   = hp_cnt_q + 8'd1;
        end
    end

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            hp_cnt_q   <= '0;
            edge_cnt_q <= '0;
        end else if (ena_i) begin
            hp_cnt_q   <= hp_cnt_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI master moving one byte per start request in any CPOL/CPHA mode, holding
// chip select across back-to-back bytes until a byte flagged last completes.
module spi_controller
    import spi_controller_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 4
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       ena,
    input  logic [1:0] mode,
    input  logic       start,
    input  logic       last,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       spi_cs_n,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    state_e     state_q, state_d;
    mode_t      mode_q, mode_d;
    logic       last_q, last_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       cs_n_q, cs_n_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       busy_q, busy_d;

    logic              run;
    logic              tick;
    logic [EDGE_W-1:0] edge_idx;
    logic              last_edge;

    // The timer also paces TEARDOWN; its edge index is simply ignored there.
    assign run       = (state_q == SETUP) || (state_q == SHIFT) || (state_q == TEARDOWN);
    assign last_edge = tick && (edge_idx == EDGES_PER_BYTE);

    spi_clk_gen #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_clk_gen (
        .clk       (clk),
        .rstb      (rstb),
        .ena_i     (ena),
        .run_i     (run),
        .tick_o    (tick),
        .edge_idx_o(edge_idx)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start)     state_d = SETUP;
            SETUP:    if (tick)      state_d = SHIFT;
            SHIFT:    if (last_edge) state_d = last_q ? TEARDOWN : GAP;
            GAP:      if (start)     state_d = SHIFT;
            TEARDOWN: if (tick)      state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        mode_d     = mode_q;
        last_d     = last_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = (state_d == SETUP) || (state_d == SHIFT) || (state_d == TEARDOWN);

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode_t'(mode);
                    last_d  = last;
                    tx_sr_d = tx_data;
                    cs_n_d  = 1'b0;
                    sclk_d  = mode_d.cpol;
                    if (!mode_d.cpha) mosi_d = tx_data[7];
                end
            end
            GAP: begin
                if (start) begin
                    last_d  = last;
                    tx_sr_d = tx_data;
                    if (!mode_q.cpha) mosi_d = tx_data[7];
                end
            end
            SETUP, SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    // Sampling edges are odd for cpha=0 and even for cpha=1.
                    if (edge_idx[0] ^ mode_q.cpha) begin
                        rx_sr_d = {rx_sr_q[6:0], spi_miso};
                    end else if (mode_q.cpha) begin
                        mosi_d  = tx_sr_q[7];
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end else if (!last_edge) begin
                        mosi_d  = tx_sr_q[6];
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                    if (last_edge) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sr_d;
                    end
                end
            end
            TEARDOWN: begin
                if (tick) cs_n_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            mode_q     <= '0;
            last_q     <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else if (ena) begin
            mode_q     <= mode_d;
            last_q     <= last_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign spi_cs_n = cs_n_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller at HALF_PERIOD=4: stimulus queues the expected
// received byte and its arrival cycle, a monitor pops and compares on every rx_valid.
module tb_spi_controller;

    localparam int H   = 4;
    localparam int LAT = 1 + 16 * H;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstb;
    logic       ena;
    logic [1:0] mode;
    logic       start;
    logic       last;
    logic [7:0] tx_data;
    logic       busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       spi_cs_n;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;

    logic       loopback;
    logic       slv_miso = 1'b0;
    logic       slv_clk_prev = 1'b0;
    logic [7:0] slv_byte;
    logic [7:0] slv_rx = 8'h00;
    int         slv_bit = 0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   cs_rises = 0;
    exp_t exp_q[$];

    spi_controller #(
        .HALF_PERIOD(H)
    ) dut (
        .clk     (clk),
        .rstb    (rstb),
        .ena     (ena),
        .mode    (mode),
        .start   (start),
        .last    (last),
        .tx_data (tx_data),
        .busy    (busy),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .spi_cs_n(spi_cs_n),
        .spi_clk (spi_clk),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge spi_cs_n) cs_rises++;

    assign spi_miso = loopback ? spi_mosi : slv_miso;

    // Mode-3 peripheral: drives on falling (leading) edges, captures on rising edges.
    always @(spi_clk or spi_cs_n) begin
        if (spi_cs_n) begin
            slv_bit = 0;
        end else if (spi_clk != slv_clk_prev) begin
            if (!spi_clk && slv_bit < 8) begin
                slv_miso = slv_byte[7 - slv_bit];
                slv_bit++;
            end else if (spi_clk) begin
                slv_rx = {slv_rx[6:0], spi_mosi};
            end
        end
        slv_clk_prev = spi_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rx_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                check("rx_valid_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [1:0] m, input logic [7:0] d, input logic l,
                         input logic push, input logic [7:0] exp_rx);
        @(negedge clk);
        mode    = m;
        tx_data = d;
        last    = l;
        start   = 1'b1;
        t0      = cyc;
        if (push) exp_q.push_back(exp_t'{exp_rx, cyc + LAT});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_done(input string name, input logic need_idle);
        int n;
        n = 0;
        while ((busy || (need_idle && !spi_cs_n)) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(n >= 400), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   r0;
        int   changes;
        logic s_clk, s_mosi;

        rstb = 1'b0; ena = 1'b1; start = 1'b0; last = 1'b0;
        mode = 2'b00; tx_data = 8'h00; loopback = 1'b1; slv_byte = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_spi_clk", spi_clk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        rstb = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0 loopback 0xA5: full timing profile.
        issue(2'b00, 8'hA5, 1'b1, 1'b1, 8'hA5);
        check("m0_cs_low_c1", spi_cs_n, 0);
        check("m0_busy_c1", busy, 1);
        check("m0_mosi_bit7_c1", spi_mosi, 1);
        check("m0_clk_idle_c1", spi_clk, 0);
        wait_until(t0 + H);
        check("m0_clk_before_edge1", spi_clk, 0);
        wait_until(t0 + 1 + H);
        check("m0_clk_edge1", spi_clk, 1);
        wait_until(t0 + 68);
        check("m0_cs_c68", spi_cs_n, 0);
        check("m0_busy_c68", busy, 1);
        wait_until(t0 + 69);
        check("m0_cs_c69", spi_cs_n, 1);
        check("m0_busy_c69", busy, 0);

        // Mode 3 against the peripheral model.
        loopback = 1'b0;
        slv_byte = 8'h3C;
        issue(2'b11, 8'hCA, 1'b1, 1'b1, 8'h3C);
        check("m3_clk_cpol_c1", spi_clk, 1);
        check("m3_cs_c1", spi_cs_n, 0);
        wait_done("m3", 1'b1);
        check("m3_periph_rx", {24'd0, slv_rx}, 32'hCA);
        check("m3_clk_idle_high", spi_clk, 1);
        loopback = 1'b1;

        issue(2'b01, 8'h81, 1'b1, 1'b1, 8'h81);
        wait_done("m1", 1'b1);
        issue(2'b10, 8'h7E, 1'b1, 1'b1, 8'h7E);
        wait_done("m2", 1'b1);
        check("m2_clk_idle_high", spi_clk, 1);

        // Two bytes under one chip select.
        r0 = cs_rises;
        issue(2'b00, 8'h10, 1'b0, 1'b1, 8'h10);
        check("gap_m0_clk_cpol_c1", spi_clk, 0);
        wait_done("gap_first", 1'b0);
        check("gap_busy_low", busy, 0);
        check("gap_cs_low", spi_cs_n, 0);
        check("gap_clk_idle", spi_clk, 0);
        repeat (3) @(negedge clk);
        check("gap_cs_still_low", spi_cs_n, 0);
        issue(2'b11, 8'h55, 1'b1, 1'b1, 8'h55);
        check("gap_busy_shift", busy, 1);
        wait_done("gap_second", 1'b1);
        check("gap_cs_single_rise", cs_rises - r0, 1);

        // start during SHIFT is ignored.
        issue(2'b00, 8'h3A, 1'b1, 1'b1, 8'h3A);
        wait_until(t0 + 20);
        tx_data = 8'hFF; last = 1'b0; mode = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(t0 + 69);
        check("ign_cs_high_c69", spi_cs_n, 1);
        check("ign_busy_c69", busy, 0);
        check("ign_clk_idle", spi_clk, 0);

        // Reset at edge 7 aborts with no rx_valid.
        issue(2'b00, 8'h96, 1'b1, 1'b0, 8'h00);
        wait_until(t0 + 1 + 7 * H);
        check("abort_clk_at_edge7", spi_clk, 1);
        rstb = 1'b0;
        #1;
        check("abort_cs_high", spi_cs_n, 1);
        check("abort_busy", busy, 0);
        check("abort_clk", spi_clk, 0);
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        repeat (70) @(negedge clk);
        issue(2'b00, 8'h5A, 1'b1, 1'b1, 8'h5A);
        wait_done("after_abort", 1'b1);

        // ena low for 20 cycles mid-SHIFT delays everything by 20 cycles.
        issue(2'b00, 8'hC3, 1'b1, 1'b1, 8'h00);
        exp_q[exp_q.size() - 1] = exp_t'{8'hC3, t0 + LAT + 20};
        wait_until(t0 + 30);
        ena = 1'b0;
        s_clk = spi_clk;
        s_mosi = spi_mosi;
        changes = 0;
        repeat (20) begin
            @(negedge clk);
            if (spi_clk !== s_clk || spi_mosi !== s_mosi) changes++;
        end
        ena = 1'b1;
        check("ena_freeze_changes", changes, 0);
        wait_done("ena", 1'b1);
        check("ena_cs_rise_cycle", cyc, t0 + 69 + 20);

        repeat (5) @(negedge clk);
        check("pending_expected", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
